// File: rtl/out_channel_reader_if.sv
// Signal bundle between the test-program core, the out-channel reader and the host link.
// The reader takes the slave view; the program and host side take the master view.
interface out_channel_reader_if #(
    parameter int MemoryElementWidth = 12
);
    logic                          write;
    logic [MemoryElementWidth-1:0] writeData;
    logic                          finish;
    logic                          success;
    logic                          outValid;
    logic                          outReady;
    logic [MemoryElementWidth-1:0] outData;
    logic                          outLast;
    logic                          overflow;
    logic                          busy;
    logic                          done;

    modport master (
        output write, writeData, finish, success, outReady,
        input  outValid, outData, outLast, overflow, busy, done
    );

    modport slave (
        input  write, writeData, finish, success, outReady,
        output outValid, outData, outLast, overflow, busy, done
    );
endinterface

// File: rtl/out_channel_reader.sv
// Buffers words pushed by the running program, then streams a framed report to the host:
// count header, buffered words, status word (bit0 success, bit1 overflow).
module out_channel_reader #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 2000
) (
    input  logic                 clock,
    input  logic                 reset,
    out_channel_reader_if.slave  bus
);
    localparam int              W     = MemoryElementWidth;
    localparam int              AW    = (NOut > 1) ? $clog2(NOut) : 1;
    localparam logic [W-1:0]    N_OUT = W'(NOut);

    typedef enum logic [2:0] {COLLECT, HEADER, DATA, STATUS, DONE} state_t;

    state_t       state;
    logic [W-1:0] mem [NOut];
    logic [W-1:0] count;
    logic [W-1:0] index;
    logic         success_q;

    logic         accept;
    logic         xfer;
    logic         ovf_next;
    logic [W-1:0] count_next;
    logic [W-1:0] status_word;

    always_comb begin
        accept      = (state == COLLECT) && bus.write && (count < N_OUT);
        ovf_next    = bus.overflow | (bus.write & ~accept);
        count_next  = count + W'(accept);
        xfer        = bus.outValid & bus.outReady;
        status_word = {{(W-2){1'b0}}, ovf_next, success_q};
    end

    // NOTE: the buffer has no reset; its contents are only read below the saved count.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[count[AW-1:0]] <= bus.writeData;
        end
    end

    // index always points at the next buffer word to present, so each transfer
    // loads the following word in the same edge and no bubble appears.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= COLLECT;
            count        <= '0;
            index        <= '0;
            success_q    <= 1'b0;
            bus.outValid <= 1'b0;
            bus.outData  <= '0;
            bus.outLast  <= 1'b0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.overflow <= ovf_next;
            case (state)
                COLLECT: begin
                    count <= count_next;
                    if (bus.finish) begin
                        state        <= HEADER;
                        success_q    <= bus.success;
                        bus.outValid <= 1'b1;
                        bus.outData  <= count_next;
                        bus.busy     <= 1'b1;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        if (count != '0) begin
                            state       <= DATA;
                            bus.outData <= mem[0];
                            index       <= W'(1);
                        end else begin
                            state       <= STATUS;
                            bus.outData <= status_word;
                            bus.outLast <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (index == count) begin
                            state       <= STATUS;
                            bus.outData <= status_word;
                            bus.outLast <= 1'b1;
                        end else begin
                            bus.outData <= mem[index[AW-1:0]];
                            index       <= index + W'(1);
                        end
                    end
                end
                STATUS: begin
                    if (xfer) begin
                        state        <= DONE;
                        bus.outValid <= 1'b0;
                        bus.outLast  <= 1'b0;
                        bus.outData  <= '0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: doc/out_channel_reader.md
Name: out_channel_reader

Overview:
- Receiving end of the program's out channel.
- The executing program pushes words one per cycle while it runs.
- When the program signals finish, this block streams a framed report to the host over a valid/ready interface: a count header, the buffered words, then a status word.
- Sits between the fpga test-program core and the host/debug link.

Parameters:
MemoryElementWidth  12    width of each channel word and of outData
NOut                2000  buffer depth in words; must satisfy NOut < 2**MemoryElementWidth

Ports:
clock       input   1                   single clock; all state changes on rising edge
reset       input   1                   asynchronous, active-high; clears all state immediately
write       input   1                   program pushes writeData this cycle
writeData   input   MemoryElementWidth  word pushed by program
finish      input   1                   program finished (level or pulse; sampled in COLLECT only)
success     input   1                   program pass flag, sampled with finish
outValid    output  1                   outData holds a valid word
outReady    input   1                   host accepts word when outValid && outReady
outData     output  MemoryElementWidth  header, data or status word
outLast     output  1                   high with the status word only
overflow    output  1                   sticky: at least one push was dropped
busy        output  1                   high in HEADER, DATA and STATUS
done        output  1                   high in DONE

Behaviour:
- Reset, asynchronous:
  - outValid=0, outData=0, outLast=0, overflow=0, busy=0, done=0.
  - Word count=0, read index=0, latched success=0.
  - State goes to COLLECT.
  - Buffer contents are don't-care.
- All outputs are registered. No combinational path from outReady to outValid or outData.
- States: COLLECT, HEADER, DATA, STATUS, DONE.
- COLLECT:
  - write && count<NOut: mem[count]=writeData; count+=1.
  - write && count==NOut: word dropped; overflow set.
  - finish: latch success; next state HEADER.
  - write and finish in the same cycle: the word is accepted normally, then HEADER.
- Writes outside COLLECT: ignored; overflow set.
- finish outside COLLECT: ignored.
- HEADER:
  - outValid=1, outData=count (zero-extended), outLast=0.
  - On handshake: go to DATA with index 0 if count>0, otherwise go to STATUS.
- DATA:
  - outData=mem[index].
  - On handshake: index+=1. Leave for STATUS after the word at index count-1 is accepted.
- STATUS:
  - outData bit0 = latched success, bit1 = overflow, upper bits 0.
  - outLast=1.
  - On handshake: go to DONE.
- DONE:
  - outValid=0, outLast=0, done=1.
  - Holds until reset.
  - The block cannot be rearmed without reset.
- Handshake rules:
  - Once outValid rises it stays high, with outData/outLast stable, until a cycle where outReady=1.
  - A transfer occurs exactly on rising edges where outValid && outReady.
- Throughput:
  - With outReady held high, one word transfers per cycle: frame length count+2 cycles after HEADER entry.
  - No bubbles between HEADER, DATA and STATUS words.
  - The buffer read is prefetched so that the next word is presented in the cycle after a transfer.
- Latency: outValid rises on the first rising edge after finish is sampled in COLLECT.
- Widths:
  - count and index are wide enough for NOut (12 bits at default).
  - No wrap-around: count saturates at NOut.
- Reset mid-frame: outputs drop to 0 asynchronously. A fresh frame requires new writes and finish.

Test Plan:
- Push 10,20,30; finish with success=1; outReady=1 → words 3,10,20,30,1 on consecutive cycles; outLast only on 1; done=1 next cycle; overflow=0.
- No pushes; finish with success=0 → words 0 then 0 with outLast=1; done=1.
- Push 5,6,7,8 with outReady toggling 1,0,0,1,0,1… → outData/outValid held stable while outReady=0; received order 4,5,6,7,8,1; no duplicates or drops.
- NOut=4; push 1..6; finish with success=1 → header 4, data 1,2,3,4, status 3 (overflow|success); overflow output=1.
- write(9) and finish in the same cycle after pushes 1,2 → header 3, data 1,2,9; a write during DATA is not emitted and sets overflow (status bit1=1).
- Assert reset while in DATA, outReady=0 → outValid/busy drop immediately; after release, push 42, finish → frame 1,42,status.
